// File: rtl/pht_ctrl.sv
// Pattern-history table controller: port A serves 1-cycle lookups, port B runs the
// post-reset clear sweep and serialized read-modify-write updates drained from a small FIFO.
module pht_ctrl #(
  parameter int         ADDR_WIDTH = 10,
  parameter int         UPD_DEPTH  = 4,
  parameter logic [1:0] INIT_CNT   = 2'b01
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  pred_valid_i,
  input  logic [ADDR_WIDTH-1:0] pred_addr_i,
  output logic                  pred_valid_o,
  output logic [1:0]            pred_cnt_o,
  output logic                  pred_taken_o,
  input  logic                  upd_valid_i,
  output logic                  upd_ready_o,
  input  logic [ADDR_WIDTH-1:0] upd_addr_i,
  input  logic                  upd_taken_i,
  output logic                  init_done_o,
  output logic                  ram_ena_o,
  output logic                  ram_wea_o,
  output logic [ADDR_WIDTH-1:0] ram_addra_o,
  output logic [1:0]            ram_dina_o,
  input  logic [1:0]            ram_douta_i,
  output logic                  ram_enb_o,
  output logic                  ram_web_o,
  output logic [ADDR_WIDTH-1:0] ram_addrb_o,
  output logic [1:0]            ram_dinb_o,
  input  logic [1:0]            ram_doutb_i
);
  localparam int DEPTH = 1 << ADDR_WIDTH;
  localparam int PW    = (UPD_DEPTH > 1) ? $clog2(UPD_DEPTH) : 1;

  typedef enum logic [1:0] {INIT, IDLE, READ, WRITE} state_t;
  typedef struct packed {
    logic [ADDR_WIDTH-1:0] addr;
    logic                  taken;
  } upd_t;

  state_t                state, state_nxt;
  logic [ADDR_WIDTH-1:0] sweep;
  logic                  init_done;

  upd_t                  fifo_q [UPD_DEPTH];
  upd_t                  head;
  logic [PW-1:0]         wr_ptr, rd_ptr;
  logic [PW:0]           count;
  logic                  full, empty, push, pop;

  logic                  en_b, we_b;
  logic [ADDR_WIDTH-1:0] addr_b;
  logic [1:0]            din_b, cnt_nxt;

  logic                  pred_vld_q, pred_init_q, byp_we_q;
  logic [ADDR_WIDTH-1:0] pred_addr_q, byp_addr_q;
  logic [1:0]            byp_din_q;

  assign full  = (count == (PW+1)'(UPD_DEPTH));
  assign empty = (count == '0);
  assign push  = upd_valid_i & ~full;
  assign head  = fifo_q[rd_ptr];

  // Saturating 2-bit counter step on the value read in the preceding READ cycle
  always_comb begin
    cnt_nxt = ram_doutb_i;
    if (head.taken) begin
      if (ram_doutb_i != 2'b11) cnt_nxt = ram_doutb_i + 2'd1;
    end else begin
      if (ram_doutb_i != 2'b00) cnt_nxt = ram_doutb_i - 2'd1;
    end
  end

  always_comb begin
    state_nxt = state;
    en_b      = 1'b0;
    we_b      = 1'b0;
    addr_b    = head.addr;
    din_b     = INIT_CNT;
    pop       = 1'b0;
    unique case (state)
      INIT: begin
        en_b   = 1'b1;
        we_b   = 1'b1;
        addr_b = sweep;
        if (sweep == ADDR_WIDTH'(DEPTH-1)) state_nxt = IDLE;
      end
      IDLE: if (!empty) state_nxt = READ;
      READ: begin
        en_b      = 1'b1;
        state_nxt = WRITE;
      end
      WRITE: begin
        en_b      = 1'b1;
        we_b      = 1'b1;
        din_b     = cnt_nxt;
        pop       = 1'b1;
        state_nxt = (count > (PW+1)'(1)) ? READ : IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= INIT;
      sweep     <= '0;
      init_done <= 1'b0;
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
    end else begin
      state <= state_nxt;
      if (state == INIT) sweep <= sweep + ADDR_WIDTH'(1);
      if (state == INIT && sweep == ADDR_WIDTH'(DEPTH-1)) init_done <= 1'b1;
      if (push) wr_ptr <= wr_ptr + PW'(1);
      if (pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + (PW+1)'(1);
        2'b01:   count <= count - (PW+1)'(1);
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr] <= '{addr: upd_addr_i, taken: upd_taken_i};
  end

  // Capture lookup and same-cycle port-B write so a colliding lookup sees the new value
  always_ff @(posedge clk) begin
    if (rst) begin
      pred_vld_q  <= 1'b0;
      pred_init_q <= 1'b0;
      byp_we_q    <= 1'b0;
    end else begin
      pred_vld_q  <= pred_valid_i;
      pred_init_q <= pred_valid_i & ~init_done;
      pred_addr_q <= pred_addr_i;
      byp_we_q    <= en_b & we_b;
      byp_addr_q  <= addr_b;
      byp_din_q   <= din_b;
    end
  end

  always_comb begin
    pred_cnt_o = 2'b00;
    if (pred_vld_q) begin
      if (pred_init_q)                                 pred_cnt_o = INIT_CNT;
      else if (byp_we_q && byp_addr_q == pred_addr_q)  pred_cnt_o = byp_din_q;
      else                                             pred_cnt_o = ram_douta_i;
    end
  end

  assign pred_valid_o = pred_vld_q;
  assign pred_taken_o = pred_cnt_o[1];
  assign upd_ready_o  = ~full;
  assign init_done_o  = init_done;

  assign ram_ena_o    = pred_valid_i & init_done & ~rst;
  assign ram_wea_o    = 1'b0;
  assign ram_addra_o  = pred_addr_i;
  assign ram_dina_o   = 2'b00;

  assign ram_enb_o    = en_b & ~rst;
  assign ram_web_o    = we_b & ~rst;
  assign ram_addrb_o  = addr_b;
  assign ram_dinb_o   = din_b;
endmodule

// File: tb/tb_pht_ctrl.sv
// Scoreboard bench for pht_ctrl with a 16-entry table: expected lookups and port-B
// writes are queued at stimulus time and popped by a negedge monitor.
module tb_pht_ctrl;
  localparam int AW = 4;
  localparam int UD = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          pred_valid_i = 1'b0;
  logic [AW-1:0] pred_addr_i = '0;
  logic          pred_valid_o;
  logic [1:0]    pred_cnt_o;
  logic          pred_taken_o;
  logic          upd_valid_i = 1'b0;
  logic          upd_ready_o;
  logic [AW-1:0] upd_addr_i = '0;
  logic          upd_taken_i = 1'b0;
  logic          init_done_o;
  logic          ram_ena_o, ram_wea_o, ram_enb_o, ram_web_o;
  logic [AW-1:0] ram_addra_o, ram_addrb_o;
  logic [1:0]    ram_dina_o, ram_dinb_o;
  logic [1:0]    ram_douta_i = 2'b00;
  logic [1:0]    ram_doutb_i = 2'b00;

  always #5 clk = ~clk;

  pht_ctrl #(.ADDR_WIDTH(AW), .UPD_DEPTH(UD), .INIT_CNT(2'b01)) dut (
    .clk(clk), .rst(rst),
    .pred_valid_i(pred_valid_i), .pred_addr_i(pred_addr_i),
    .pred_valid_o(pred_valid_o), .pred_cnt_o(pred_cnt_o), .pred_taken_o(pred_taken_o),
    .upd_valid_i(upd_valid_i), .upd_ready_o(upd_ready_o),
    .upd_addr_i(upd_addr_i), .upd_taken_i(upd_taken_i),
    .init_done_o(init_done_o),
    .ram_ena_o(ram_ena_o), .ram_wea_o(ram_wea_o), .ram_addra_o(ram_addra_o),
    .ram_dina_o(ram_dina_o), .ram_douta_i(ram_douta_i),
    .ram_enb_o(ram_enb_o), .ram_web_o(ram_web_o), .ram_addrb_o(ram_addrb_o),
    .ram_dinb_o(ram_dinb_o), .ram_doutb_i(ram_doutb_i)
  );

  // Dual-port RAM: registered read, zero after idle cycle, old data on read-during-write
  logic [1:0] mem [16];
  always @(posedge clk) begin
    ram_douta_i <= ram_ena_o ? mem[ram_addra_o] : 2'b00;
    ram_doutb_i <= ram_enb_o ? mem[ram_addrb_o] : 2'b00;
    if (ram_enb_o && ram_web_o) mem[ram_addrb_o] <= ram_dinb_o;
    if (ram_ena_o && ram_wea_o) mem[ram_addra_o] <= ram_dina_o;
  end

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [1:0]    din;
  } wr_t;

  wr_t        wq [$];
  logic [1:0] lq [$];
  int         total = 0;
  int         passed = 0;
  int         cyc = 0;
  int         c0 = 0;
  wr_t        mon_w;
  logic [1:0] mon_l;
  logic [1:0] sat [8];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  always @(negedge clk) begin
    if (pred_valid_o) begin
      if (lq.size() == 0) begin
        total++;
        $display("FAIL pred_unexpected: got cnt %0h expected no lookup result", pred_cnt_o);
      end else begin
        mon_l = lq.pop_front();
        chk("pred_cnt", 32'(pred_cnt_o), 32'(mon_l));
        chk("pred_taken", 32'(pred_taken_o), 32'(mon_l[1]));
      end
    end
    if (ram_enb_o && ram_web_o) begin
      if (wq.size() == 0) begin
        total++;
        $display("FAIL wr_unexpected: got addr %0h din %0h expected no write", ram_addrb_o, ram_dinb_o);
      end else begin
        mon_w = wq.pop_front();
        chk("wr_addr", 32'(ram_addrb_o), 32'(mon_w.addr));
        chk("wr_din", 32'(ram_dinb_o), 32'(mon_w.din));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Holds valid until accepted; caller drops upd_valid_i when the burst ends
  task automatic push_upd(input logic [AW-1:0] a, input logic t, input logic [1:0] exp, input bit expect_wr);
    bit ok;
    ok = 1'b0;
    upd_valid_i = 1'b1;
    upd_addr_i  = a;
    upd_taken_i = t;
    if (expect_wr) wq.push_back('{addr: a, din: exp});
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (upd_ready_o) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) begin
      total++;
      $display("FAIL push_timeout: got upd_ready_o 0 expected 1 within 200 cycles");
    end
    step();
  endtask

  task automatic lookup(input logic [AW-1:0] a, input logic [1:0] exp);
    pred_valid_i = 1'b1;
    pred_addr_i  = a;
    lq.push_back(exp);
    step();
    pred_valid_i = 1'b0;
  endtask

  task automatic drain();
    for (int i = 0; i < 200; i++) begin
      if (wq.size() == 0) break;
      @(negedge clk);
    end
    chk("wq_drain", 32'(wq.size()), 32'd0);
    step();
    step();
  endtask

  task automatic wait_init();
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (init_done_o) break;
    end
    chk("init_done_wait", 32'(init_done_o), 32'd1);
  endtask

  initial begin
    for (int i = 0; i < 16; i++) mem[i] = 2'b11;
    sat = '{2'b10, 2'b11, 2'b11, 2'b11, 2'b10, 2'b01, 2'b00, 2'b00};

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_init_done", 32'(init_done_o), 32'd0);
    chk("rst_pred_valid", 32'(pred_valid_o), 32'd0);
    chk("rst_pred_cnt", 32'(pred_cnt_o), 32'd0);
    chk("rst_upd_ready", 32'(upd_ready_o), 32'd1);
    chk("rst_ram_en", 32'({ram_ena_o, ram_enb_o}), 32'd0);

    for (int i = 0; i < 16; i++) wq.push_back('{addr: AW'(i), din: 2'b01});
    @(posedge clk);
    #1;
    rst = 1'b0;
    c0  = cyc;

    // Fill FIFO during the sweep; 5th request must be held
    push_upd(4'd10, 1'b1, 2'b10, 1'b1);
    push_upd(4'd11, 1'b0, 2'b00, 1'b1);
    push_upd(4'd12, 1'b1, 2'b10, 1'b1);
    push_upd(4'd13, 1'b0, 2'b00, 1'b1);
    upd_addr_i  = 4'd14;
    upd_taken_i = 1'b1;
    @(negedge clk);
    chk("fifo_full_ready", 32'(upd_ready_o), 32'd0);
    lookup(4'd7, 2'b01);

    while (cyc < c0 + 15) @(negedge clk);
    chk("init_done_pre", 32'(init_done_o), 32'd0);
    chk("fifo_held", 32'(upd_ready_o), 32'd0);
    @(negedge clk);
    chk("init_done_rise", 32'(init_done_o), 32'd1);

    push_upd(4'd14, 1'b1, 2'b10, 1'b1);
    upd_valid_i = 1'b0;
    drain();
    lookup(4'd10, 2'b10);
    lookup(4'd11, 2'b00);
    lookup(4'd13, 2'b00);
    lookup(4'd7,  2'b01);

    // Saturation on addr 3
    for (int i = 0; i < 8; i++) begin
      push_upd(4'd3, (i < 4), sat[i], 1'b1);
      upd_valid_i = 1'b0;
      drain();
      lookup(4'd3, sat[i]);
    end

    // Back-to-back updates to one address
    push_upd(4'd5, 1'b1, 2'b10, 1'b1);
    push_upd(4'd5, 1'b1, 2'b11, 1'b1);
    push_upd(4'd5, 1'b1, 2'b11, 1'b1);
    upd_valid_i = 1'b0;
    drain();
    lookup(4'd5, 2'b11);

    // Lookup colliding with the WRITE cycle: bypass vs. unrelated address
    push_upd(4'd9, 1'b1, 2'b10, 1'b1);
    upd_valid_i = 1'b0;
    step();
    step();
    chk("byp_in_write", 32'({ram_enb_o, ram_web_o, ram_addrb_o}), 32'({1'b1, 1'b1, 4'd9}));
    lookup(4'd9, 2'b10);
    drain();
    push_upd(4'd9, 1'b1, 2'b11, 1'b1);
    upd_valid_i = 1'b0;
    step();
    step();
    lookup(4'd8, 2'b01);
    drain();
    lookup(4'd9, 2'b11);

    // Reset during WRITE of addr 2 with another update queued
    push_upd(4'd2, 1'b1, 2'b00, 1'b0);
    push_upd(4'd4, 1'b1, 2'b00, 1'b0);
    upd_valid_i = 1'b0;
    step();
    chk("mid_write_cyc", 32'({ram_enb_o, ram_web_o, ram_addrb_o}), 32'({1'b1, 1'b1, 4'd2}));
    for (int i = 0; i < 16; i++) wq.push_back('{addr: AW'(i), din: 2'b01});
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_no_write", 32'({ram_enb_o, ram_web_o}), 32'd0);
    step();
    chk("mid_rst_ready", 32'(upd_ready_o), 32'd1);
    chk("mid_rst_init_done", 32'(init_done_o), 32'd0);
    rst = 1'b0;
    wait_init();
    repeat (10) step();
    drain();
    lookup(4'd2, 2'b01);
    lookup(4'd4, 2'b01);

    repeat (3) step();
    chk("lq_empty", 32'(lq.size()), 32'd0);
    chk("wq_empty", 32'(wq.size()), 32'd0);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish before 200000");
    $fatal(1);
  end
endmodule
